dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters: the processor MEM stage ("core") and a debug/loader port ("dbg").
- Sequences each access: select, issue, wait for memory latency, return response.
- Sits between the MEM stage and the data memory block.
- Lets the data memory be preloaded and inspected at run time without a testbench backdoor.

Parameters:
- ADDR_W, 32, address width in bits (word address).
- DATA_W, 32, data width in bits.
- MEM_LAT, 1, cycles from the mem_en cycle to a valid mem_rdata (legal range 1..15).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  one-cycle pulse when the core request is issued.
- core_rvalid  out  1  one-cycle pulse when the core access completes (read data valid, or write done).
- core_rdata  out  DATA_W  core read data, valid with core_rvalid.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same directions, widths and meanings as the core_* ports, for the debug port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on port reset.
- Reset values: FSM = IDLE; every gnt/rvalid output = 0; mem_en = 0; mem_we = 0; mem_addr/mem_wdata/core_rdata/dbg_rdata = 0; wait counter = 0; last_owner = DBG, so the core wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One requester active: select it.
  - Both active: select the requester that is not last_owner (round-robin).
  - On selection: register owner, we, addr and wdata into the mem_* registers; next state ISSUE.
- ISSUE (exactly one cycle):
  - mem_en = 1.
  - gnt of the owner = 1; the other gnt = 0.
  - last_owner <= owner.
  - Counter loaded with MEM_LAT-1; next state WAIT.
- WAIT:
  - mem_en = 0.
  - Decrement the counter. When the counter reaches 0, capture mem_rdata into the owner's rdata register and go to RESP.
  - Writes take the same path and timing. The rdata register is not updated on writes (it holds its previous value).
- RESP (one cycle):
  - Owner's rvalid = 1; then IDLE.
  - No arbitration in RESP.
- Latency: req first seen at edge k -> gnt in cycle k+1 -> rvalid in cycle k+2+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles.
- Request hold rule: requesters keep req/we/addr/wdata stable until gnt. Dropping req before gnt is allowed only while the arbiter is in IDLE; a request seen in IDLE is committed.
- A request arriving during ISSUE/WAIT/RESP waits; it is considered at the next IDLE cycle.
- The non-owner's rdata register is never modified.
- Reset asserted mid-access:
  - Immediate return to IDLE.
  - The pending access is dropped with no rvalid.
  - A write already strobed in ISSUE is not undone.
- Simultaneous requests: outcome decided solely by last_owner. Both requesters continuously active -> grants alternate core, dbg, core, ...

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds outputs perf_core_cnt (32), perf_dbg_cnt (32) and perf_conflict_cnt (32).
  - perf_core_cnt / perf_dbg_cnt increment on each ISSUE cycle of that owner.
  - perf_conflict_cnt increments in every cycle where both reqs are high and the FSM is in IDLE.
  - All three reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Owner encoding: OWN_CORE=1'b0, OWN_DBG=1'b1.
  - Latency counter width constant: 4.
- Sub-module rr_pick2: two-input round-robin selector; combinational pick plus the registered last_owner. All other logic stays in the top module.

Test Plan:
- Reset, MEM_LAT=1, core read of addr 3 with mem block[3]=32'h100 -> core_gnt at cycle k+1, core_rvalid at k+3, core_rdata=32'h100, dbg_* stay 0.
- dbg write addr 10 data 32'h120, then core read addr 10 -> one mem_en/mem_we cycle with addr 10; core_rdata=32'h120.
- core_req and dbg_req both high from reset, held 4 accesses -> grant order core, dbg, core, dbg; exactly one gnt per ISSUE.
- MEM_LAT=3, core read -> rvalid exactly 5 cycles after the first req cycle; mem_en high for exactly one cycle.
- Reset low during WAIT of a dbg read -> outputs drop to 0 asynchronously; no dbg_rvalid; the next request is granted normally after reset release.
- DMEM_ARB_PERF_EN defined, 2 overlapping core+dbg requests -> perf_core_cnt=1, perf_dbg_cnt=1, perf_conflict_cnt equals the IDLE cycles with both reqs high (1 for this scenario).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter, rr_pick2).
// Optional performance counters are enabled with DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

    // Value loaded into the wait counter so the WAIT phase lasts exactly lat cycles.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/dmem_arb_rr_pick2.sv
// Two-input round-robin selector: combinational pick plus the registered last owner.
// On a tie the requester that did not own the previous access wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   req_core_i,
    input  logic   req_dbg_i,
    input  logic   update_i,
    input  owner_e owner_i,
    output logic   valid_o,
    output owner_e pick_o
);

    owner_e last_q;
    owner_e last_d;

    // Pick the requester; ties go to whoever is not last_q.
    always_comb begin
        valid_o = req_core_i | req_dbg_i;
        pick_o  = OWN_CORE;
        if (req_core_i && req_dbg_i) begin
            pick_o = (last_q == OWN_CORE) ? OWN_DBG : OWN_CORE;
        end else if (req_dbg_i) begin
            pick_o = OWN_DBG;
        end else begin
            pick_o = OWN_CORE;
        end
    end

    // Next value of the last-owner record.
    always_comb begin
        last_d = last_q;
        if (update_i) begin
            last_d = owner_i;
        end else begin
            last_d = last_q;
        end
    end

    // Last-owner register; resets to DBG so the core wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OWN_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the core MEM stage and a debug/loader port.
// Define DMEM_ARB_PERF_EN to add saturating grant/conflict performance counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_core_cnt,
    output logic [31:0]       perf_dbg_cnt,
    output logic [31:0]       perf_conflict_cnt
`endif
);

    state_e             state_q,       state_d;
    owner_e             owner_q,       owner_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic               mem_en_q,      mem_en_d;
    logic               mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q,   mem_wdata_d;
    logic               core_gnt_q,    core_gnt_d;
    logic               dbg_gnt_q,     dbg_gnt_d;
    logic               core_rvalid_q, core_rvalid_d;
    logic               dbg_rvalid_q,  dbg_rvalid_d;
    logic [DATA_W-1:0]  core_rdata_q,  core_rdata_d;
    logic [DATA_W-1:0]  dbg_rdata_q,   dbg_rdata_d;

    logic   pick_valid_s;
    owner_e pick_s;
    logic   issue_s;

    assign issue_s = (state_q == ISSUE);

    rr_pick2 u_pick (
        .clk_i      (clk),
        .rst_ni     (reset),
        .req_core_i (core_req),
        .req_dbg_i  (dbg_req),
        .update_i   (issue_s),
        .owner_i    (owner_q),
        .valid_o    (pick_valid_s),
        .pick_o     (pick_s)
    );

    // Access sequencer: strobes and grants are computed one state ahead so every output is a flop.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        mem_en_d      = 1'b0;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        core_gnt_d    = 1'b0;
        dbg_gnt_d     = 1'b0;
        core_rvalid_d = 1'b0;
        dbg_rvalid_d  = 1'b0;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    owner_d     = pick_s;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (pick_s == OWN_CORE) ? core_we    : dbg_we;
                    mem_addr_d  = (pick_s == OWN_CORE) ? core_addr  : dbg_addr;
                    mem_wdata_d = (pick_s == OWN_CORE) ? core_wdata : dbg_wdata;
                    core_gnt_d  = (pick_s == OWN_CORE);
                    dbg_gnt_d   = (pick_s == OWN_DBG);
                    state_d     = ISSUE;
                end else begin
                    state_d     = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = lat_load(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    // Writes complete on the same schedule but leave rdata untouched.
                    if (!mem_we_q && (owner_q == OWN_CORE)) begin
                        core_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        dbg_rdata_d  = mem_rdata;
                    end else begin
                        core_rdata_d = core_rdata_q;
                    end
                    core_rvalid_d = (owner_q == OWN_CORE);
                    dbg_rvalid_d  = (owner_q == OWN_DBG);
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_CORE;
            cnt_q         <= CNT_ZERO;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_wdata_q   <= {DATA_W{1'b0}};
            core_gnt_q    <= 1'b0;
            dbg_gnt_q     <= 1'b0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= {DATA_W{1'b0}};
            dbg_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            core_gnt_q    <= core_gnt_d;
            dbg_gnt_q     <= dbg_gnt_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign core_gnt    = core_gnt_q;
    assign dbg_gnt     = dbg_gnt_q;
    assign core_rvalid = core_rvalid_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_core_q, perf_core_d;
    logic [31:0] perf_dbg_q,  perf_dbg_d;
    logic [31:0] perf_conf_q, perf_conf_d;

    // Saturating counters: grants per owner and IDLE cycles with both requesters waiting.
    always_comb begin
        perf_core_d = perf_core_q;
        perf_dbg_d  = perf_dbg_q;
        perf_conf_d = perf_conf_q;
        if (issue_s && (owner_q == OWN_CORE)) begin
            perf_core_d = sat_inc32(perf_core_q);
        end else if (issue_s) begin
            perf_dbg_d  = sat_inc32(perf_dbg_q);
        end else begin
            perf_core_d = perf_core_q;
        end
        if ((state_q == IDLE) && core_req && dbg_req) begin
            perf_conf_d = sat_inc32(perf_conf_q);
        end else begin
            perf_conf_d = perf_conf_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_core_q <= 32'd0;
            perf_dbg_q  <= 32'd0;
            perf_conf_q <= 32'd0;
        end else begin
            perf_core_q <= perf_core_d;
            perf_dbg_q  <= perf_dbg_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_core_cnt     = perf_core_q;
    assign perf_dbg_cnt      = perf_dbg_q;
    assign perf_conflict_cnt = perf_conf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Counter checks are included when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        core_req_3, core_we_3, dbg_req_3, dbg_we_3;
    logic [31:0] core_addr_3, core_wdata_3, dbg_addr_3, dbg_wdata_3;
    logic        core_gnt_3, core_rvalid_3, dbg_gnt_3, dbg_rvalid_3;
    logic [31:0] core_rdata_3, dbg_rdata_3;
    logic        mem_en_3, mem_we_3;
    logic [31:0] mem_addr_3, mem_wdata_3, mem_rdata_3;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_core_cnt, perf_dbg_cnt, perf_conflict_cnt;
    logic [31:0] perf_core_cnt_3, perf_dbg_cnt_3, perf_conflict_cnt_3;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_core_cnt(perf_core_cnt), .perf_dbg_cnt(perf_dbg_cnt),
        .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .core_req(core_req_3), .core_we(core_we_3), .core_addr(core_addr_3), .core_wdata(core_wdata_3),
        .core_gnt(core_gnt_3), .core_rvalid(core_rvalid_3), .core_rdata(core_rdata_3),
        .dbg_req(dbg_req_3), .dbg_we(dbg_we_3), .dbg_addr(dbg_addr_3), .dbg_wdata(dbg_wdata_3),
        .dbg_gnt(dbg_gnt_3), .dbg_rvalid(dbg_rvalid_3), .dbg_rdata(dbg_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3)
`ifdef DMEM_ARB_PERF_EN
        , .perf_core_cnt(perf_core_cnt_3), .perf_dbg_cnt(perf_dbg_cnt_3),
        .perf_conflict_cnt(perf_conflict_cnt_3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: contents restored while reset is low; read data is poisoned outside its slot.
    logic [31:0] mem  [16];
    logic [31:0] mem3 [16];
    logic [31:0] p1, p3a, p3b, p3c;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]  <= (i == 3) ? 32'h100 : (32'h1000 + 32'(i));
                mem3[i] <= (i == 3) ? 32'h100 : (32'h1000 + 32'(i));
            end
            p1 <= 32'hDEAD_BEEF; p3a <= 32'hDEAD_BEEF; p3b <= 32'hDEAD_BEEF; p3c <= 32'hDEAD_BEEF;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[3:0]] <= mem_wdata;
            if (mem_en_3 && mem_we_3) mem3[mem_addr_3[3:0]] <= mem_wdata_3;
            p1  <= mem_en ? mem[mem_addr[3:0]] : 32'hDEAD_BEEF;
            p3a <= mem_en_3 ? mem3[mem_addr_3[3:0]] : 32'hDEAD_BEEF;
            p3b <= p3a;
            p3c <= p3b;
        end
    end
    assign mem_rdata   = p1;
    assign mem_rdata_3 = p3c;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int en3_cnt = 0;
    logic [31:0] cq[$], dq[$], c3q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, inout logic [31:0] q[$], input logic [31:0] obs);
        if (q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: unexpected rvalid, rdata %0h, expected no response", tag, obs);
        end else begin
            check(tag, obs, q.pop_front());
        end
    endtask

    // Advance to the next falling edge and do the per-cycle scoreboard work.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (core_rvalid)   sb_pop("core_rdata", cq, core_rdata);
        if (dbg_rvalid)    sb_pop("dbg_rdata", dq, dbg_rdata);
        if (core_rvalid_3) sb_pop("core_rdata_lat3", c3q, core_rdata_3);
        if (dbg_rvalid_3)  sb_pop("dbg_rdata_lat3", dq, dbg_rdata_3);
        if (core_gnt && dbg_gnt) check("gnt_onehot", 32'd1, 32'd0);
        if (mem_en && mem_we) wr_cnt++;
        if (mem_en_3) en3_cnt++;
    endtask

    // Uncontended access on the MEM_LAT=1 instance; called and returns in an IDLE cycle.
    task automatic acc(input bit is_dbg, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        int n;
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dq.push_back(exp);
        end else begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; cq.push_back(exp);
        end
        n = 0;
        do begin tick(); n++; end while (!(is_dbg ? dbg_gnt : core_gnt) && n < 20);
        check("gnt_latency", 32'(n), 32'd1);
        check("mem_en_at_gnt", 32'(mem_en), 32'd1);
        check("mem_we_at_gnt", 32'(mem_we), 32'(we));
        check("mem_addr_at_gnt", mem_addr, addr);
        if (we) check("mem_wdata_at_gnt", mem_wdata, wdata);
        check("other_gnt_low", 32'(is_dbg ? core_gnt : dbg_gnt), 32'd0);
        if (is_dbg) dbg_req = 1'b0; else core_req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!(is_dbg ? dbg_rvalid : core_rvalid) && n < 20);
        check("rvalid_latency", 32'(n), 32'd2);
        tick();
    endtask

    initial begin
        int n, g, last_cyc;
        reset = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'd0; core_wdata = 32'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
        core_req_3 = 1'b0; core_we_3 = 1'b0; core_addr_3 = 32'd0; core_wdata_3 = 32'd0;
        dbg_req_3 = 1'b0; dbg_we_3 = 1'b0; dbg_addr_3 = 32'd0; dbg_wdata_3 = 32'd0;
        repeat (3) tick();
        check("rst_core_gnt", 32'(core_gnt), 32'd0);
        check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        reset = 1'b1;
        tick();

        // Core read of a preloaded word; debug side must stay quiet.
        acc(1'b0, 1'b0, 32'd3, 32'd0, 32'h100);
        check("dbg_rdata_untouched", dbg_rdata, 32'd0);

        // Debug write followed by a core read of the same word.
        acc(1'b1, 1'b1, 32'd10, 32'h120, 32'd0);
        check("single_write_strobe", 32'(wr_cnt), 32'd1);
        acc(1'b0, 1'b0, 32'd10, 32'd0, 32'h120);
        check("write_keeps_dbg_rdata", dbg_rdata, 32'd0);

        // MEM_LAT=3 instance: gnt after one edge, rvalid five cycles after the request cycle.
        core_req_3 = 1'b1; core_addr_3 = 32'd3; c3q.push_back(32'h100);
        n = 0;
        do begin tick(); n++; end while (!core_gnt_3 && n < 20);
        check("lat3_gnt_latency", 32'(n), 32'd1);
        core_req_3 = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!core_rvalid_3 && n < 30);
        check("lat3_rvalid_latency", 32'(n + 1), 32'd5);
        tick();
        check("lat3_mem_en_cycles", 32'(en3_cnt), 32'd1);

        // Both requesters held from reset: grants alternate core, dbg, core, dbg every 4 cycles.
        reset = 1'b0;
        tick();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'd3;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd5;
        cq.push_back(32'h100); cq.push_back(32'h100);
        dq.push_back(32'h1005); dq.push_back(32'h1005);
        tick();
        reset = 1'b1;
        g = 0; n = 0; last_cyc = 0;
        while (g < 4 && n < 40) begin
            tick(); n++;
            if (core_gnt || dbg_gnt) begin
                check("rr_order", 32'(dbg_gnt), 32'(g % 2));
                if (g > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
                g++;
                if (g == 4) begin core_req = 1'b0; dbg_req = 1'b0; end
            end
        end
        check("rr_grant_count", 32'(g), 32'd4);
        repeat (6) tick();
        check("rr_core_drained", 32'(cq.size()), 32'd0);
        check("rr_dbg_drained", 32'(dq.size()), 32'd0);

        // Reset during WAIT of a debug read drops the access without a response.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd6;
        tick();
        check("abort_dbg_gnt", 32'(dbg_gnt), 32'd1);
        dbg_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("abort_async_mem_addr", mem_addr, 32'd0);
        check("abort_async_dbg_rdata", dbg_rdata, 32'd0);
        check("abort_async_core_rdata", core_rdata, 32'd0);
        check("abort_async_mem_en", 32'(mem_en), 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("abort_no_rvalid", 32'(dbg_rvalid), 32'd0);
        acc(1'b1, 1'b0, 32'd7, 32'd0, 32'h1007);

`ifdef DMEM_ARB_PERF_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'd3;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd5;
        cq.push_back(32'h100); dq.push_back(32'h1005);
        repeat (14) begin
            tick();
            if (core_gnt) core_req = 1'b0;
            if (dbg_gnt) dbg_req = 1'b0;
        end
        check("perf_core_cnt", perf_core_cnt, 32'd1);
        check("perf_dbg_cnt", perf_dbg_cnt, 32'd1);
        check("perf_conflict_cnt", perf_conflict_cnt, 32'd1);
        check("perf_queues_drained", 32'(cq.size() + dq.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
